// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: register geometry, data/address/enable types, SEW/LMUL encodings
// and the writeback sequencer state enum.
package riscv_v_pkg;

   localparam int unsigned RISCV_V_NUM_BYTES_DATA = 16;
   localparam int unsigned RISCV_V_NUM_REGS       = 32;

   typedef logic [8*RISCV_V_NUM_BYTES_DATA-1:0]  riscv_v_data_t;
   typedef logic [$clog2(RISCV_V_NUM_REGS)-1:0]  riscv_v_rf_addr_t;
   typedef logic [RISCV_V_NUM_BYTES_DATA-1:0]    riscv_v_rf_wr_en_t;

   typedef enum logic [1:0] {Sew8, Sew16, Sew32, Sew64} riscv_v_sew_t;
   typedef enum logic [1:0] {Lmul1, Lmul2, Lmul4, Lmul8} riscv_v_lmul_t;
   typedef enum logic [1:0] {StIdle, StBusy, StFlush} riscv_v_wb_state_t;

endpackage

// File: rtl/riscv_v_wb_byte_en.sv
// Per-byte write enable for beat k of a register group: a byte is enabled when its element lies
// below vl_eff (and, with RISCV_V_WB_MASK_EN, its v0 mask bit is set or the op is unmasked).
module riscv_v_wb_byte_en
   import riscv_v_pkg::*;
#(
   parameter int unsigned NUM_BYTES = RISCV_V_NUM_BYTES_DATA,
   parameter int unsigned VL_W      = $clog2(8*NUM_BYTES)+1
) (
   input  logic [2:0]             k,
   input  riscv_v_sew_t           sew,
   input  logic [VL_W-1:0]        vl_eff,
`ifdef RISCV_V_WB_MASK_EN
   input  logic                   vm,
   input  logic [8*NUM_BYTES-1:0] mask,
`endif
   output logic [NUM_BYTES-1:0]   byte_en
);

   localparam int unsigned MaskIdxW = $clog2(8*NUM_BYTES);

   int unsigned elem;

   always_comb begin
      byte_en = '0;
      elem    = 0;
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
         elem       = 32'(k) * (NUM_BYTES >> sew) + (b >> sew);
         byte_en[b] = elem < 32'(vl_eff);
`ifdef RISCV_V_WB_MASK_EN
         if (!vm && !mask[elem[MaskIdxW-1:0]]) begin
            byte_en[b] = 1'b0;
         end
`endif
      end
   end

endmodule

// File: rtl/riscv_v_rf_wb.sv
// Vector writeback sequencer: turns one request plus nregs result beats into registered RF
// writes with tail-undisturbed byte enables. Define RISCV_V_WB_MASK_EN to add v0 masking.
module riscv_v_rf_wb
   import riscv_v_pkg::*;
#(
   parameter int unsigned NUM_BYTES = RISCV_V_NUM_BYTES_DATA,
   parameter int unsigned VL_W      = $clog2(8*NUM_BYTES)+1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  riscv_v_rf_addr_t       req_vd,
   input  logic [1:0]             req_sew,
   input  logic [1:0]             req_lmul,
   input  logic [VL_W-1:0]        req_vl,
`ifdef RISCV_V_WB_MASK_EN
   input  logic                   req_vm,
   input  logic [8*NUM_BYTES-1:0] req_mask,
`endif
   input  logic                   beat_valid,
   output logic                   beat_ready,
   input  riscv_v_data_t          beat_data,
   output riscv_v_rf_addr_t       rf_wr_addr,
   output riscv_v_data_t          rf_wr_data,
   output riscv_v_rf_wr_en_t      rf_wr_en,
   output logic                   done,
   output logic                   err
);

   riscv_v_wb_state_t state_q, state_d;
   riscv_v_rf_addr_t  vd_q, vd_d;
   riscv_v_sew_t      sew_q, sew_d;
   riscv_v_lmul_t     lmul_q, lmul_d;
   logic [VL_W-1:0]   vl_q, vl_d;
   logic [2:0]        k_q, k_d;
   logic              err_q, err_d;
   riscv_v_rf_addr_t  wr_addr_q, wr_addr_d;
   riscv_v_data_t     wr_data_q, wr_data_d;
   riscv_v_rf_wr_en_t wr_en_q, wr_en_d;
`ifdef RISCV_V_WB_MASK_EN
   logic                   vm_q, vm_d;
   logic [8*NUM_BYTES-1:0] mask_q, mask_d;
`endif

   logic [VL_W-1:0]   vlmax, vl_clip;
   riscv_v_rf_addr_t  grp_mask;
   logic [2:0]        last_k;
   riscv_v_rf_wr_en_t beat_en;

   assign vlmax    = VL_W'((NUM_BYTES >> req_sew) << req_lmul);
   assign vl_clip  = (req_vl < vlmax) ? req_vl : vlmax;
   // Low address bits that must be zero for the group base to be LMUL-aligned.
   assign grp_mask = riscv_v_rf_addr_t'((6'd1 << req_lmul) - 6'd1);
   assign last_k   = 3'((4'd1 << lmul_q) - 4'd1);

   riscv_v_wb_byte_en #(
      .NUM_BYTES (NUM_BYTES),
      .VL_W      (VL_W)
   ) u_byte_en (
      .k       (k_q),
      .sew     (sew_q),
      .vl_eff  (vl_q),
`ifdef RISCV_V_WB_MASK_EN
      .vm      (vm_q),
      .mask    (mask_q),
`endif
      .byte_en (beat_en)
   );

   always_comb begin
      state_d   = state_q;
      vd_d      = vd_q;
      sew_d     = sew_q;
      lmul_d    = lmul_q;
      vl_d      = vl_q;
      k_d       = k_q;
      err_d     = err_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = '0;
`ifdef RISCV_V_WB_MASK_EN
      vm_d      = vm_q;
      mask_d    = mask_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               vd_d   = req_vd;
               sew_d  = riscv_v_sew_t'(req_sew);
               lmul_d = riscv_v_lmul_t'(req_lmul);
               vl_d   = vl_clip;
               k_d    = '0;
               err_d  = (req_vd & grp_mask) != '0;
`ifdef RISCV_V_WB_MASK_EN
               vm_d   = req_vm;
               mask_d = req_mask;
`endif
               state_d = (err_d || vl_clip == '0) ? StFlush : StBusy;
            end
         end
         StBusy: begin
            if (beat_valid) begin
               wr_en_d   = beat_en;
               wr_addr_d = vd_q + riscv_v_rf_addr_t'(k_q);
               wr_data_d = beat_data;
               k_d       = k_q + 3'd1;
               if (k_q == last_k) begin
                  state_d = StFlush;
               end
            end
         end
         StFlush: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         vd_q      <= '0;
         sew_q     <= Sew8;
         lmul_q    <= Lmul1;
         vl_q      <= '0;
         k_q       <= '0;
         err_q     <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= '0;
`ifdef RISCV_V_WB_MASK_EN
         vm_q      <= 1'b1;
         mask_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         vd_q      <= vd_d;
         sew_q     <= sew_d;
         lmul_q    <= lmul_d;
         vl_q      <= vl_d;
         k_q       <= k_d;
         err_q     <= err_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
`ifdef RISCV_V_WB_MASK_EN
         vm_q      <= vm_d;
         mask_q    <= mask_d;
`endif
      end
   end

   assign req_ready  = state_q == StIdle;
   assign beat_ready = state_q == StBusy;
   assign done       = state_q == StFlush;
   assign err        = done && err_q;
   assign rf_wr_addr = wr_addr_q;
   assign rf_wr_data = wr_data_q;
   assign rf_wr_en   = wr_en_q;

endmodule

// File: tb/tb_riscv_v_rf_wb.sv
// Randomised bench for riscv_v_rf_wb: element-level reference model, per-cycle compare,
// plus directed cases with literal expectations.
module tb_riscv_v_rf_wb;
   import riscv_v_pkg::*;

   localparam int NB = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   riscv_v_rf_addr_t req_vd = '0;
   logic [1:0]       req_sew = '0;
   logic [1:0]       req_lmul = '0;
   logic [7:0]       req_vl = '0;
`ifdef RISCV_V_WB_MASK_EN
   logic             req_vm = 1'b1;
   logic [127:0]     req_mask = '0;
`endif
   logic             beat_valid = 1'b0;
   logic             beat_ready;
   riscv_v_data_t    beat_data = '0;
   riscv_v_rf_addr_t rf_wr_addr;
   riscv_v_data_t    rf_wr_data;
   riscv_v_rf_wr_en_t rf_wr_en;
   logic             done;
   logic             err;

   riscv_v_rf_wb dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_vd     (req_vd),
      .req_sew    (req_sew),
      .req_lmul   (req_lmul),
      .req_vl     (req_vl),
`ifdef RISCV_V_WB_MASK_EN
      .req_vm     (req_vm),
      .req_mask   (req_mask),
`endif
      .beat_valid (beat_valid),
      .beat_ready (beat_ready),
      .beat_data  (beat_data),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data),
      .rf_wr_en   (rf_wr_en),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Reference model: phase 0 waiting for request, 1 collecting beats, 2 completion cycle.
   int          phase = 0;
   int          m_k, m_nregs, m_vd;
   bit          m_err;
   logic [127:0] grp;
   logic [15:0] exp_en = '0;
   logic [4:0]  exp_addr = '0;
   logic [127:0] exp_data = '0;
   bit          exp_req_ready = 1'b1, exp_beat_ready = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
   bit          exp_addr_chk = 1'b0;

   always @(posedge clk) begin
      int   nregs, esz, vlmax, vl_eff;
      bit   m_vm;
      logic [127:0] m_mask;
`ifdef RISCV_V_WB_MASK_EN
      m_vm = req_vm;
      m_mask = req_mask;
`else
      m_vm = 1'b1;
      m_mask = '1;
`endif
      exp_en = '0;
      exp_addr_chk = 1'b0;
      if (rst) begin
         phase = 0;
         m_err = 1'b0;
         exp_addr = '0;
         exp_data = '0;
         exp_addr_chk = 1'b1;
      end else begin
         case (phase)
            0: if (req_valid) begin
               nregs  = 1 << req_lmul;
               esz    = 1 << req_sew;
               vlmax  = (NB / esz) * nregs;
               vl_eff = (int'(req_vl) < vlmax) ? int'(req_vl) : vlmax;
               m_vd   = int'(req_vd);
               m_k    = 0;
               m_nregs = nregs;
               m_err  = (m_vd % nregs) != 0;
               if (m_err || vl_eff == 0) begin
                  phase = 2;
               end else begin
                  grp = '0;
                  for (int e = 0; e < vl_eff; e++)
                     if (m_vm || m_mask[e])
                        for (int j = 0; j < esz; j++) grp[e*esz+j] = 1'b1;
                  phase = 1;
               end
            end
            1: if (beat_valid) begin
               exp_en   = grp[m_k*NB +: NB];
               exp_addr = 5'(m_vd + m_k);
               exp_data = beat_data;
               exp_addr_chk = 1'b1;
               m_k++;
               if (m_k == m_nregs) phase = 2;
            end
            default: phase = 0;
         endcase
      end
      exp_req_ready  = phase == 0;
      exp_beat_ready = phase == 1;
      exp_done       = phase == 2;
      exp_err        = (phase == 2) && m_err;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", 128'(req_ready), 128'(exp_req_ready));
         check("beat_ready", 128'(beat_ready), 128'(exp_beat_ready));
         check("rf_wr_en", 128'(rf_wr_en), 128'(exp_en));
         check("done", 128'(done), 128'(exp_done));
         check("err", 128'(err), 128'(exp_err));
         if (exp_addr_chk) begin
            check("rf_wr_addr", 128'(rf_wr_addr), 128'(exp_addr));
            check("rf_wr_data", rf_wr_data, exp_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input int vd, input int sew, input int lmul, input int vl);
      req_vd    = 5'(vd);
      req_sew   = 2'(sew);
      req_lmul  = 2'(lmul);
      req_vl    = 8'(vl);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      logic [127:0] d;
      int tmp;
      tick();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst req_ready", 128'(req_ready), 128'd1);
      check("rst beat_ready", 128'(beat_ready), 128'd0);
      check("rst rf_wr_en", 128'(rf_wr_en), 128'd0);
      check("rst rf_wr_addr", 128'(rf_wr_addr), 128'd0);
      check("rst rf_wr_data", rf_wr_data, 128'd0);
      check("rst done", 128'(done), 128'd0);
      check("rst err", 128'(err), 128'd0);
      tick();
      rst = 1'b0;

      // SEW=8 LMUL=1 vd=3 vl=16
      send_req(3, 0, 0, 16);
      beat_valid = 1'b1;
      beat_data  = {16{8'hAA}};
      tick();
      beat_valid = 1'b0;
      @(negedge clk);
      check("t1 addr", 128'(rf_wr_addr), 128'd3);
      check("t1 en", 128'(rf_wr_en), 128'hFFFF);
      check("t1 data", rf_wr_data, {16{8'hAA}});
      check("t1 done", 128'(done), 128'd1);
      tick();

      // SEW=32 LMUL=1 vd=1 vl=3
      send_req(1, 2, 0, 3);
      beat_valid = 1'b1;
      beat_data  = {4{$urandom}};
      tick();
      beat_valid = 1'b0;
      @(negedge clk);
      check("t2 en", 128'(rf_wr_en), 128'h0FFF);
      check("t2 addr", 128'(rf_wr_addr), 128'd1);
      tick();

      // SEW=16 LMUL=2 vd=4 vl=10 with a one-cycle beat gap
      send_req(4, 1, 1, 10);
      beat_valid = 1'b1;
      beat_data  = {4{$urandom}};
      tick();
      beat_valid = 1'b0;
      @(negedge clk);
      check("t3 addr0", 128'(rf_wr_addr), 128'd4);
      check("t3 en0", 128'(rf_wr_en), 128'hFFFF);
      check("t3 done early", 128'(done), 128'd0);
      tick();
      beat_valid = 1'b1;
      beat_data  = {4{$urandom}};
      @(negedge clk);
      check("t3 gap en", 128'(rf_wr_en), 128'd0);
      tick();
      beat_valid = 1'b0;
      @(negedge clk);
      check("t3 addr1", 128'(rf_wr_addr), 128'd5);
      check("t3 en1", 128'(rf_wr_en), 128'h000F);
      check("t3 done", 128'(done), 128'd1);
      tick();

      // Misaligned group, beats offered but not consumed
      send_req(6, 0, 2, 8);
      beat_valid = 1'b1;
      @(negedge clk);
      check("t4 done", 128'(done), 128'd1);
      check("t4 err", 128'(err), 128'd1);
      check("t4 beat_ready", 128'(beat_ready), 128'd0);
      tick();
      @(negedge clk);
      check("t4 idle beat_ready", 128'(beat_ready), 128'd0);
      check("t4 idle en", 128'(rf_wr_en), 128'd0);
      beat_valid = 1'b0;
      send_req(0, 0, 0, 0);
      @(negedge clk);
      check("t4 vl0 done", 128'(done), 128'd1);
      check("t4 vl0 err", 128'(err), 128'd0);
      tick();

      // Reset after the first of four beats
      send_req(8, 0, 2, 64);
      beat_valid = 1'b1;
      beat_data  = {4{$urandom}};
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("t5 first en", 128'(rf_wr_en), 128'hFFFF);
      check("t5 first addr", 128'(rf_wr_addr), 128'd8);
      tick();
      rst = 1'b0;
      beat_valid = 1'b0;
      @(negedge clk);
      check("t5 req_ready", 128'(req_ready), 128'd1);
      check("t5 en", 128'(rf_wr_en), 128'd0);
      send_req(0, 0, 0, 5);
      beat_valid = 1'b1;
      tick();
      beat_valid = 1'b0;
      @(negedge clk);
      check("t5 fresh en", 128'(rf_wr_en), 128'h001F);
      check("t5 fresh done", 128'(done), 128'd1);
      tick();

`ifdef RISCV_V_WB_MASK_EN
      req_vm   = 1'b0;
      req_mask = 128'h5;
      send_req(2, 2, 0, 4);
      beat_valid = 1'b1;
      tick();
      beat_valid = 1'b0;
      @(negedge clk);
      check("t6 masked en", 128'(rf_wr_en), 128'h0F0F);
      tick();
      req_vm = 1'b1;
      send_req(2, 2, 0, 4);
      beat_valid = 1'b1;
      tick();
      beat_valid = 1'b0;
      @(negedge clk);
      check("t6 unmasked en", 128'(rf_wr_en), 128'hFFFF);
      tick();
`endif

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst       = $urandom_range(0, 199) == 0;
         req_valid = $urandom_range(0, 3) == 0;
         req_sew   = 2'($urandom_range(0, 3));
         req_lmul  = 2'($urandom_range(0, 3));
         tmp       = int'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) tmp = tmp & ~((1 << req_lmul) - 1);
         req_vd    = 5'(tmp);
         req_vl    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
`ifdef RISCV_V_WB_MASK_EN
         req_vm    = $urandom_range(0, 1) == 1;
         req_mask  = {4{$urandom}};
`endif
         beat_valid = $urandom_range(0, 9) < 7;
         d = {$urandom, $urandom, $urandom, $urandom};
         beat_data = d;
      end
      rst = 1'b0;
      req_valid = 1'b0;
      beat_valid = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
